// File: rtl/code_seq_pkg.sv
// Shared types and helpers for the code sequencer.
// Optional Gray-coded output is selected with CODE_SEQ_GRAY_EN.
package code_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Works for any code width up to 32; callers truncate to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/code_seq_counter.sv
// WIDTH-bit load/up/down/hold counter with natural wrap.
// Exposes the next value so the owner can register a derived form of it.
module code_seq_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] d
);

    always_comb begin
        d = q;
        if (load)
            d = load_val;
        else if (step)
            d = up ? q + WIDTH'(1) : q - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else
            q <= d;
    end

endmodule

// File: rtl/code_sequencer.sv
// Sweeps a code from First to Last, one per clock, with Start/Done handshake, Hold and Abort.
// Define CODE_SEQ_GRAY_EN to drive W as the Gray form of the internal binary count.
module code_sequencer
    import code_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] First,
    input  logic [WIDTH-1:0] Last,
    input  logic             Up,
    input  logic             Hold,
    input  logic             Abort,
    output logic [WIDTH-1:0] W,
    output logic             En,
    output logic             Busy,
    output logic             Done
);

    state_t           state, state_nx;
    logic [WIDTH-1:0] last_r;
    logic             up_r;
    logic             load, step;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    code_seq_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (Clock),
        .rst_n    (Resetn),
        .load     (load),
        .load_val (First),
        .step     (step),
        .up       (up_r),
        .q        (cnt_q),
        .d        (cnt_d)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Abort) begin
                    state_nx = ST_RUN;
                    load     = 1'b1;
                end
            end
            ST_RUN: begin
                if (Abort)
                    state_nx = ST_IDLE;
                else if (!Hold) begin
                    if (cnt_q == last_r)
                        state_nx = ST_DONE;
                    else
                        step = 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Flags are registered from the next state so they line up with the new code.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= ST_IDLE;
            last_r <= '0;
            up_r   <= 1'b0;
            En     <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                last_r <= Last;
                up_r   <= Up;
            end
            En   <= (state_nx == ST_RUN);
            Busy <= (state_nx == ST_RUN);
            Done <= (state_nx == ST_DONE);
        end
    end

`ifdef CODE_SEQ_GRAY_EN
    logic [WIDTH-1:0] w_r;
    logic [31:0]      gray_nx;

    assign gray_nx = bin2gray(32'(cnt_d));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            w_r <= '0;
        else
            w_r <= gray_nx[WIDTH-1:0];
    end

    assign W = w_r;
`else
    assign W = cnt_q;
`endif

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer (WIDTH=4); honours CODE_SEQ_GRAY_EN.
module tb_code_sequencer;

    localparam int WIDTH = 4;
    localparam int M     = 1 << WIDTH;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b0;
    logic             Start = 1'b0;
    logic [WIDTH-1:0] First = '0;
    logic [WIDTH-1:0] Last = '0;
    logic             Up = 1'b0;
    logic             Hold = 1'b0;
    logic             Abort = 1'b0;
    logic [WIDTH-1:0] W;
    logic             En, Busy, Done;

    int compared   = 0;
    int mismatched = 0;

    code_sequencer #(.WIDTH(WIDTH)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .First(First), .Last(Last),
        .Up(Up), .Hold(Hold), .Abort(Abort), .W(W), .En(En), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int first;
        int last;
        int up;
        int mode;   // 0 no hold, 1 random hold, 2 hold twice at code 3
        int exp_en; // required En cycles
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bin_at(input int first, input int up, input int i);
        return up ? ((first + i) & (M - 1)) : ((first - i) & (M - 1));
    endfunction

    function automatic int exp_w(input int first, input int up, input int i);
        int b;
        b = bin_at(first, up, i);
`ifdef CODE_SEQ_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic run_sweep(input vec_t v, input string nm);
        int n, idx, cyc, holds, en_cyc;
        bit hold;
        n = (v.up != 0) ? (((v.last - v.first) & (M - 1)) + 1)
                        : (((v.first - v.last) & (M - 1)) + 1);
        Start = 1'b1; First = WIDTH'(v.first); Last = WIDTH'(v.last);
        Up = (v.up != 0); Hold = 1'b0;
        tick();
        First = WIDTH'($urandom); Last = WIDTH'($urandom); Up = 1'($urandom);
        idx = 0; cyc = 0; holds = 0; en_cyc = 0;
        while (idx < n && cyc < 200) begin
            chk({nm, " W"}, 32'(W), 32'(exp_w(v.first, v.up, idx)));
            chk({nm, " En"}, 32'(En), 1);
            chk({nm, " Busy"}, 32'(Busy), 1);
            chk({nm, " Done"}, 32'(Done), 0);
            if (En) en_cyc++;
            case (v.mode)
                1:       hold = ($urandom % 3) == 0;
                2:       hold = (bin_at(v.first, v.up, idx) == 3) && (holds < 2);
                default: hold = 1'b0;
            endcase
            if (hold) holds++;
            Hold  = hold;
            Start = 1'($urandom);
            tick();
            cyc++;
            if (!hold) idx++;
        end
        if (cyc >= 200) chk({nm, " timeout"}, 1, 0);
        Hold = 1'b0; Start = 1'b1;
        chk({nm, " done pulse"}, 32'(Done), 1);
        chk({nm, " done En"}, 32'(En), 0);
        chk({nm, " done Busy"}, 32'(Busy), 0);
        chk({nm, " done W"}, 32'(W), 32'(exp_w(v.first, v.up, n - 1)));
        tick();
        Start = 1'b0;
        chk({nm, " idle Done"}, 32'(Done), 0);
        chk({nm, " idle Busy"}, 32'(Busy), 0);
        chk({nm, " idle En"}, 32'(En), 0);
        chk({nm, " En cycles"}, 32'(en_cyc), 32'(v.exp_en + ((v.mode == 1) ? holds : 0)));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{first: 2,  last: 5,  up: 1, mode: 0, exp_en: 4};
        vecs[1] = '{first: 14, last: 1,  up: 1, mode: 0, exp_en: 4};
        vecs[2] = '{first: 1,  last: 14, up: 0, mode: 0, exp_en: 4};
        vecs[3] = '{first: 7,  last: 7,  up: 1, mode: 0, exp_en: 1};
        vecs[4] = '{first: 2,  last: 5,  up: 1, mode: 2, exp_en: 6};
        vecs[5] = '{first: 0,  last: 15, up: 1, mode: 0, exp_en: 16};
        vecs[6] = '{first: 15, last: 0,  up: 0, mode: 0, exp_en: 16};
        vecs[7] = '{first: 3,  last: 2,  up: 1, mode: 1, exp_en: 16};

        repeat (2) @(posedge Clock);
        #1;
        chk("reset W", 32'(W), 0);
        chk("reset En", 32'(En), 0);
        chk("reset Busy", 32'(Busy), 0);
        chk("reset Done", 32'(Done), 0);
        Resetn = 1'b1;
        tick();

        for (int i = 0; i < 8; i++)
            run_sweep(vecs[i], $sformatf("vec%0d", i));

        // Abort at W=4 of 2..9, with Start asserted on the same edge.
        Start = 1'b1; First = 4'd2; Last = 4'd9; Up = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        chk("abort pre W", 32'(W), 32'(exp_w(2, 1, 2)));
        Abort = 1'b1; Start = 1'b1;
        tick();
        chk("abort En", 32'(En), 0);
        chk("abort Busy", 32'(Busy), 0);
        chk("abort Done", 32'(Done), 0);
        chk("abort W", 32'(W), 32'(exp_w(2, 1, 2)));
        tick();
        chk("abort+start Busy", 32'(Busy), 0);
        Abort = 1'b0; Start = 1'b0;
        tick();
        chk("abort no Done", 32'(Done), 0);
        chk("abort idle En", 32'(En), 0);

`ifdef CODE_SEQ_GRAY_EN
        begin
            int gseq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
            Start = 1'b1; First = 4'd0; Last = 4'd15; Up = 1'b1;
            tick();
            Start = 1'b0;
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("gray W%0d", i), 32'(W), 32'(gseq[i]));
                tick();
            end
            chk("gray Done", 32'(Done), 1);
            tick();
        end
`endif

        for (int r = 0; r < 20; r++) begin
            vec_t v;
            v.first = int'($urandom_range(0, M - 1));
            v.last  = int'($urandom_range(0, M - 1));
            v.up    = int'($urandom_range(0, 1));
            v.mode  = 1;
            v.exp_en = (v.up != 0) ? (((v.last - v.first) % M + M) % M + 1)
                                   : (((v.first - v.last) % M + M) % M + 1);
            run_sweep(v, $sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of a sweep.
        Start = 1'b1; First = 4'd0; Last = 4'd15; Up = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        #2;
        Resetn = 1'b0;
        #1;
        chk("midrun reset W", 32'(W), 0);
        chk("midrun reset En", 32'(En), 0);
        chk("midrun reset Busy", 32'(Busy), 0);
        chk("midrun reset Done", 32'(Done), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        chk("post reset Busy", 32'(Busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
